// File: rtl/instruction_prefetch_buffer.sv
// Circular FIFO between the fetch and decode stages. The fetch PC is held while the
// buffer is full. A taken jump (flush) empties the buffer in a single cycle.
module instruction_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [19:0]              fetchAddress,
    input  logic [IW-1:0]            fetchInstr,
    input  logic                     fetchValid,
    input  logic                     flush,
    output logic                     stall,
    input  logic                     decodeReady,
    output logic                     decodeValid,
    output logic [19:0]              decodeAddress,
    output logic [IW-1:0]            decodeInstr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 20 + IW;

    // The initialisers give a defined empty state before the first reset.
    logic [PW-1:0] rd_ptr = '0;
    logic [PW-1:0] wr_ptr = '0;
    logic [CW-1:0] occ    = '0;

    logic [EW-1:0] mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [EW-1:0] head;

    // full/empty come from registered occupancy only, so stall has no input path.
    assign full  = (occ == CW'(DEPTH));
    assign empty = (occ == '0);
    assign stall = full;

    assign push = fetchValid & ~full & ~flush & ~reset;

    assign decodeValid = ~empty & ~flush;
    assign pop         = decodeValid & decodeReady & ~reset;

    assign head          = mem[rd_ptr];
    assign decodeAddress = head[EW-1:IW];
    assign decodeInstr   = head[IW-1:0];
    assign count         = occ;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    // Storage is data only; it is never reset and is written only on an accepted push.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {fetchAddress, fetchInstr};
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_buffer.sv
// Directed bench for instruction_prefetch_buffer. A queue-based reference model is
// compared against the DUT every cycle, and hand-computed literal checks are added.
module tb_instruction_prefetch_buffer;

    localparam int DEPTH = 4;
    localparam int IW    = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [19:0]   fetchAddress = '0;
    logic [IW-1:0] fetchInstr = '0;
    logic          fetchValid = 1'b0;
    logic          flush = 1'b0;
    logic          stall;
    logic          decodeReady = 1'b0;
    logic          decodeValid;
    logic [19:0]   decodeAddress;
    logic [IW-1:0] decodeInstr;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19+IW:0] mq[$];

    instruction_prefetch_buffer #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clock(clock), .reset(reset),
        .fetchAddress(fetchAddress), .fetchInstr(fetchInstr), .fetchValid(fetchValid),
        .flush(flush), .stall(stall), .decodeReady(decodeReady),
        .decodeValid(decodeValid), .decodeAddress(decodeAddress),
        .decodeInstr(decodeInstr), .count(count)
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] mk_instr(input logic [19:0] a);
        return {a[11:0], a} ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an occupancy queue updated with the block's accept rules.
    always @(posedge clock) begin
        logic do_push;
        logic do_pop;
        if (reset || flush) begin
            mq.delete();
        end else begin
            do_push = fetchValid && (mq.size() < DEPTH);
            do_pop  = decodeReady && (mq.size() != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({fetchAddress, fetchInstr});
        end
    end

    always @(posedge clock) begin
        #2;
        check("cmp_count", 32'(count), 32'(mq.size()));
        check("cmp_stall", 32'(stall), 32'(mq.size() == DEPTH));
        check("cmp_valid", 32'(decodeValid), 32'((mq.size() != 0) && !flush));
        if (mq.size() != 0) begin
            check("cmp_addr",  32'(decodeAddress), 32'(mq[0][19+IW:IW]));
            check("cmp_instr", 32'(decodeInstr),   32'(mq[0][IW-1:0]));
        end
    end

    task automatic drive(input logic rs, input logic fv, input logic [19:0] a,
                         input logic fl, input logic dr);
        @(negedge clock);
        reset        = rs;
        fetchValid   = fv;
        fetchAddress = a;
        fetchInstr   = mk_instr(a);
        flush        = fl;
        decodeReady  = dr;
        #1;
    endtask

    initial begin
        #2;
        check("init_count", 32'(count), 32'd0);

        // Fill, then a word presented while full is refused.
        drive(1'b0, 1'b1, 20'h00000, 1'b0, 1'b0);
        check("rst_valid", 32'(decodeValid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        drive(1'b0, 1'b1, 20'h00001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00002, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00003, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00004, 1'b0, 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_stall", 32'(stall), 32'd1);
        drive(1'b0, 1'b1, 20'h00004, 1'b0, 1'b0);
        check("full_hold", 32'(count), 32'd4);

        // Drain in order.
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("drain0", 32'(decodeAddress), 32'h00000);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("drain1", 32'(decodeAddress), 32'h00001);
        check("drain_stall", 32'(stall), 32'd0);
        check("drain_cnt", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("drain2", 32'(decodeAddress), 32'h00002);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("drain3", 32'(decodeAddress), 32'h00003);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        check("drain_empty", 32'(count), 32'd0);
        check("drain_valid", 32'(decodeValid), 32'd0);

        // Streaming with wrap-around.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 20'h00010 + 20'(i), 1'b0, 1'b1);
            if (i > 0) begin
                check("stream_addr", 32'(decodeAddress), 32'h10 + 32'(i) - 32'd1);
                check("stream_cnt", 32'(count), 32'd1);
            end
        end
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("stream_last", 32'(decodeAddress), 32'h00019);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        check("stream_empty", 32'(count), 32'd0);

        // Flush with three entries and a simultaneous push.
        drive(1'b0, 1'b1, 20'h00040, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00041, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00042, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00050, 1'b1, 1'b1);
        check("flush_valid_comb", 32'(decodeValid), 32'd0);
        check("flush_cnt_pre", 32'(count), 32'd3);
        drive(1'b0, 1'b1, 20'h00A00, 1'b0, 1'b0);
        check("flush_cnt", 32'(count), 32'd0);
        check("flush_valid", 32'(decodeValid), 32'd0);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("jump_target", 32'(decodeAddress), 32'h00A00);
        check("jump_valid", 32'(decodeValid), 32'd1);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);

        // Reset mid-operation with push and pop pending.
        drive(1'b0, 1'b1, 20'h00060, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00061, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 20'h00062, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 20'h00070, 1'b0, 1'b0);
        check("mrst_cnt", 32'(count), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_valid", 32'(decodeValid), 32'd0);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("mrst_next", 32'(decodeAddress), 32'h00070);
        check("mrst_cnt1", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);

        // One-cycle fetch-to-decode latency.
        drive(1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b1);
        check("lat_push_cycle", 32'(decodeValid), 32'd0);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("lat_valid", 32'(decodeValid), 32'd1);
        check("lat_addr", 32'(decodeAddress), 32'hFFFFF);
        check("lat_instr", 32'(decodeInstr), 32'(mk_instr(20'hFFFFF)));
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        check("lat_empty", 32'(count), 32'd0);

        // Pop while full: no push that cycle, next push a cycle later.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 20'h00080 + 20'(i), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 20'h00084, 1'b0, 1'b1);
        check("fp_full", 32'(count), 32'd4);
        drive(1'b0, 1'b1, 20'h00084, 1'b0, 1'b1);
        check("fp_cnt", 32'(count), 32'd3);
        check("fp_stall", 32'(stall), 32'd0);
        check("fp_head", 32'(decodeAddress), 32'h00081);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("fp_cnt2", 32'(count), 32'd3);
        check("fp_head2", 32'(decodeAddress), 32'h00082);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b1);
        check("fp_tail", 32'(decodeAddress), 32'h00084);
        drive(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
        check("fp_empty", 32'(count), 32'd0);

        @(posedge clock);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_buffer.md
INSTRUCTION_PREFETCH_BUFFER -- requirements
Module: instruction_prefetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of buffer entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter IW, default 32, meaning instruction word width in bits.
REQ-003 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Port fetchAddress  input  20  address of the word presented by the fetch stage (the fetch PC output).
REQ-006 Port fetchInstr  input  IW  instruction word read from instruction memory at fetchAddress.
REQ-007 Port fetchValid  input  1  fetchAddress/fetchInstr carry a valid word this cycle.
REQ-008 Port flush  input  1  taken jump; discard all buffered words (driven by the same signal as the fetch stage's jumpEnable).
REQ-009 Port stall  output  1  to the fetch stage: hold PC; high exactly when the buffer is full.
REQ-010 Port decodeReady  input  1  decode stage accepts the head entry this cycle.
REQ-011 Port decodeValid  output  1  head entry is valid.
REQ-012 Port decodeAddress  output  20  address of the head entry.
REQ-013 Port decodeInstr  output  IW  instruction word of the head entry.
REQ-014 Port count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH entries of {address[19:0], instr[IW-1:0]}, with read/write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-016 full SHALL be count==DEPTH and empty SHALL be count==0, both derived from registered state only.
REQ-017 stall SHALL equal full, with no combinational path from any input.
REQ-018 A push SHALL occur on a rising edge iff fetchValid=1, full=0, flush=0 and reset=0; a push writes {fetchAddress, fetchInstr} at the write pointer and advances it.
REQ-019 fetchValid=1 while full=1 SHALL be ignored without corrupting state; the fetch stage re-presents the word because the PC is held.
REQ-020 decodeValid SHALL equal (!empty && !flush).
REQ-021 decodeAddress and decodeInstr SHALL show the entry at the read pointer whenever empty=0; their value while empty=1 is don't-care.
REQ-022 A pop SHALL occur on a rising edge iff decodeValid=1 and decodeReady=1; a pop advances the read pointer.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers; this is legal at any count from 1 to DEPTH-1.
REQ-024 There SHALL be no bypass: a word pushed into an empty buffer appears on decodeValid one cycle later, giving a fetch-to-decode latency of exactly 1 cycle.
REQ-025 The push rule SHALL prevent any push while full, even when a pop happens in the same cycle; the buffer frees a slot first and accepts the next push one cycle later.
REQ-026 flush=1 SHALL, on the rising edge, set count=0 and both pointers to 0, and suppress any same-cycle push or pop.
REQ-027 Priority SHALL be reset > flush > push/pop.
REQ-028 count SHALL update as count + push - pop and SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-029 On reset=1 at a rising edge, count, the read pointer and the write pointer SHALL become 0; stall and decodeValid are then 0 in the following cycle.
REQ-030 Storage contents SHALL NOT require reset.
REQ-031 Reset asserted mid-operation (buffer partially full, with a push and pop pending) SHALL discard all entries identically to power-up reset, with no push or pop taking effect.
REQ-032 At simulation start, before the first reset, count SHALL initialise to 0.

Verification
REQ-033 Fill and stall: reset; decodeReady=0; push addresses 0x00000..0x00003, then present 0x00004 -> count=4, stall=1, and 0x00004 is not stored.
REQ-034 Drain order: from the filled state, decodeReady=1 -> decode sees 0x00000, 0x00001, 0x00002, 0x00003 on consecutive cycles; stall drops after the first pop; count reaches 0 and decodeValid=0.
REQ-035 Streaming and wrap-around: fetchValid=1 and decodeReady=1 continuously for 10 words, addresses 0x00010..0x00019 -> count stays at 1 after the first cycle, decode order is exact, and the pointers wrap twice.
REQ-036 Flush: with 3 entries and a simultaneous push of 0x00050, flush=1 -> next cycle count=0, decodeValid=0; 0x00050 is not stored; a subsequent push of jump target 0x00A00 is the next decoded word.
REQ-037 Reset mid-operation: with 2 entries, apply reset=1 together with a push and pop -> count=0 and stall=0 next cycle; the first word pushed after reset is the next decoded word.
REQ-038 Latency: push 0xFFFFF into an empty buffer with decodeReady=1 -> decodeValid=0 in the push cycle; decodeValid=1 with decodeAddress=0xFFFFF in the following cycle.
